// File: rtl/rr_channel_sequencer_if.sv
// rtl/rr_channel_sequencer_if.sv - request/grant bundle between channels and the round-robin sequencer
//
// Purpose: groups the request inputs and grant outputs of rr_channel_sequencer.
// Signals:
//   req[15:0]      per-channel request, bit n = channel n
//   done           current grant holder finished
//   grant_en       grant held; drives the 4-to-16 decoder enable
//   grant_idx[3:0] granted channel; drives the decoder select
//   busy           sequencer in GRANT or GAP
//   timeout        one-cycle pulse when the watchdog forces a release
// Modports: slave = sequencer side, master = channel/driver side.

interface rr_channel_sequencer_if;
  logic [15:0] req;
  logic        done;
  logic        grant_en;
  logic [3:0]  grant_idx;
  logic        busy;
  logic        timeout;

  modport slave (
    input  req, done,
    output grant_en, grant_idx, busy, timeout
  );

  modport master (
    output req, done,
    input  grant_en, grant_idx, busy, timeout
  );
endinterface

// File: rtl/rr_channel_sequencer.sv
// rtl/rr_channel_sequencer.sv - 16-channel round-robin grant sequencer feeding a 4-to-16 decoder
//
// Purpose: picks one requesting channel with rotating priority, holds the grant
// until done (or the optional watchdog), then forces one low cycle before the
// next grant so decoded lines never overlap.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  rr_channel_sequencer_if.slave (req, done in; grant_en, grant_idx, busy, timeout out)
// Parameters:
//   MAX_HOLD  watchdog limit in GRANT cycles (2..65535)
//   CNT_W     watchdog counter width, 2**CNT_W > MAX_HOLD
// Optional feature macro: RR_SEQ_TIMEOUT_EN enables the grant watchdog; when
// undefined no counter exists and timeout stays 0.

module rr_channel_sequencer #(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 16
) (
  input logic                   clk,
  input logic                   rst,
  rr_channel_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_idx_q, grant_idx_d;
  logic [3:0] last_ptr_q, last_ptr_d;
  logic       grant_en_q, grant_en_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [3:0] winner;
  logic       winner_vld;
  logic [3:0] scan_idx;
  logic       limit_hit;

  // Rotating scan: offsets 1..16 from last_ptr; the 4-bit wrap makes offset 16
  // land on last_ptr itself, so the previous winner has lowest priority.
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    scan_idx   = '0;
    for (int i = 1; i <= 16; i++) begin
      scan_idx = last_ptr_q + 4'(i);
      if (!winner_vld && bus.req[scan_idx]) begin
        winner     = scan_idx;
        winner_vld = 1'b1;
      end
    end
  end

`ifdef RR_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside GRANT, so it is already clear on GRANT entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == GRANT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_HOLD == CNT_W);
  assign limit_hit  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    last_ptr_d  = last_ptr_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (winner_vld) begin
          state_d     = GRANT;
          grant_idx_d = winner;
          last_ptr_d  = winner;
        end
      end
      GRANT: begin
        // done has priority: a simultaneous limit hit is a normal release.
        if (bus.done) begin
          state_d = GAP;
        end else if (limit_hit) begin
          state_d   = GAP;
          timeout_d = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are flopped from the next state so the decoder sees glitch-free levels.
    grant_en_d = (state_d == GRANT);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_idx_q <= 4'd0;
      last_ptr_q  <= 4'd15;
      grant_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_ptr_q  <= last_ptr_d;
      grant_en_q  <= grant_en_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.grant_en  = grant_en_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: doc/rr_channel_sequencer.md
# rr_channel_sequencer

Round-robin arbiter/sequencer selecting one of 16 requesting channels and presenting the winner as a binary index plus enable. Sits directly upstream of the 4-to-16 one-hot decoder: `grant_idx` drives the decoder's `in[3:0]`, and `grant_en` drives its `enable`, so exactly one decoded line is active per grant. Holds each grant until the channel signals completion, then re-arbitrates with rotating priority.

## Interface
- `MAX_HOLD`, default 64: grant watchdog limit in cycles; used only with `RR_SEQ_TIMEOUT_EN`; legal range 2..65535.
- `CNT_W`, default 16: watchdog counter width; must satisfy 2^CNT_W > MAX_HOLD.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  16  per-channel request; bit n = channel n.
- `done`  in  1  current grant holder finished; sampled only in GRANT.
- `grant_en`  out  1  high while a grant is held; feeds decoder `enable`.
- `grant_idx`  out  4  index of granted channel; feeds decoder `in`.
- `busy`  out  1  high in GRANT and GAP states.
- `timeout`  out  1  one-cycle pulse on watchdog release; constant 0 when the watchdog is compiled out.

## Operation
- FSM states: IDLE, GRANT, GAP.
- IDLE: if `req != 0`, select the winner, load `grant_idx`, then go to GRANT. Otherwise stay in IDLE.
- GRANT: `grant_en=1`, and `grant_idx` is stable. If `done` is sampled high, go to GAP.
- GAP: `grant_en=0` for exactly one cycle, then go to IDLE. This guarantees a decoder-output low cycle between consecutive grants.
- Winner selection:
  - Scan starts at `(last_ptr+1) mod 16` and increments with wrap.
  - The first set `req` bit wins.
  - `last_ptr` loads the winner index on entry to GRANT.
- `grant_idx` holds its last value in IDLE/GAP and is don't-care to the decoder, because `enable=0` then.
- During GRANT, `req` changes are ignored, including the holder dropping its request. Only `done` (or the watchdog) ends a grant.
- `done` in IDLE or GAP is ignored.
- All-zero `req` never produces a grant.

## Timing
- Reset values:
  - state=IDLE, `grant_en=0`, `grant_idx=0`, `busy=0`, `timeout=0`.
  - `last_ptr=15`, so channel 0 has highest priority after reset.
  - Watchdog count=0.
- Arbitration latency: `req` sampled in IDLE at edge k, giving `grant_en=1` and a valid `grant_idx` after edge k.
- Release:
  - `done` sampled at edge k gives `grant_en=0` after edge k.
  - The earliest next `grant_en=1` is after edge k+2.
  - Minimum grant period is therefore 3 cycles (GRANT, GAP, IDLE).
- Simultaneous `done` and new `req` in GRANT: `done` wins. The new request is arbitrated in IDLE as normal.
- Reset mid-grant: at the reset edge all outputs return to reset values and `last_ptr` returns to 15. Reset overrides `done` and the watchdog.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `RR_SEQ_TIMEOUT_EN` defined:
  - A `CNT_W`-bit counter clears on GRANT entry and increments each GRANT cycle.
  - When the counter reaches `MAX_HOLD-1` with `done` low, the FSM goes to GAP.
  - `timeout` pulses high for the GAP cycle only.
  - The release then behaves exactly like `done` release, including `last_ptr` rotation.
  - `done` and the limit in the same cycle count as a normal release, with `timeout=0`.
- `RR_SEQ_TIMEOUT_EN` undefined: no counter is synthesized, `timeout` is tied 0, and a grant lasts indefinitely until `done`.

## Test plan
- Reset priority: after reset, `req=16'h8001` held, then `done` pulsed after 2 GRANT cycles.
  - First grant: `grant_idx=0`.
  - After one GAP cycle: `grant_idx=15`.
  - Next grant: `grant_idx=0` again.
- Wrap-around: force `last_ptr=14` via a prior grant of channel 14, then `req=16'h4003` → grants are 0, 1, 14 in sequence.
- Latency/gap: `req=16'h0010` set in IDLE at edge k → `grant_en=1`, `grant_idx=4` after k. `done` at edge k+3 → `grant_en=0` after k+3, and `grant_en=1` again after k+5.
- Request drop and stray done: pulse `done` in IDLE → no state change. Grant channel 7, then drop `req[7]` → `grant_en` stays 1 until `done`.
- Mid-grant reset: `rst=1` while GRANT on channel 9 → all outputs 0 next cycle. With `req=16'h0200` still high after reset, channel 9 is granted one cycle after `rst` falls.
- Watchdog (with `RR_SEQ_TIMEOUT_EN`, `MAX_HOLD=4`): `req=16'h0004`, `done` held 0 → `grant_en` high 4 cycles, then `timeout=1` for 1 cycle with `grant_en=0`, then re-grant of channel 2. Without the macro, `grant_en` stays high for 100+ cycles and `timeout` stays 0.
